// File: rtl/alu_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// alu_arbiter_ctrl
//
// Shares one purely combinational ALU between two requesters. Requester 0 is
// the switch/button front-end and requester 1 is the self-test pattern
// generator. The block does the following:
//   - picks a requester round-robin,
//   - registers the granted operands and opcode onto the ALU inputs,
//   - holds them for SETTLE cycles,
//   - captures the ALU output,
//   - returns it, tagged with the requester id, on a valid/ready channel.
// Only one operation is ever in flight.
//
// Ports:
//   clk, reset_n            system clock; synchronous active-low reset
//   reqN_valid/ready        request handshake per requester (N = 0, 1);
//                           ready is combinational
//   reqN_a/b/op             operands and opcode, sampled only on handshake
//   alu_a/alu_b/alu_op      registered ALU inputs
//   alu_y                   combinational ALU result
//   rsp_valid/ready         response handshake
//   rsp_id/y/err            owner id, captured result, illegal-opcode flag
//   busy                    high whenever an operation is in progress
// -----------------------------------------------------------------------------
module alu_arbiter_ctrl #(
    parameter int WIDTH   = 4,
    parameter int OPW     = 3,
    parameter int NUM_OPS = 6,
    parameter int SETTLE  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // One extra bit so that NUM_OPS == 2**OPW is still representable.
    localparam logic [OPW:0] NUM_OPS_W = (OPW + 1)'(NUM_OPS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_e;

    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   alu_a_q,      alu_a_d;
    logic [WIDTH-1:0]   alu_b_q,      alu_b_d;
    logic [OPW-1:0]     alu_op_q,     alu_op_d;
    logic               rsp_valid_q,  rsp_valid_d;
    logic               rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0]   rsp_y_q,      rsp_y_d;
    logic               rsp_err_q,    rsp_err_d;

    logic               grant;
    logic               accept_en;
    logic               handshake;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [OPW-1:0]     sel_op;

    // Arbitration. Only requester 1 valid -> grant 1. Only requester 0 valid
    // (or none) -> grant 0. Both valid -> the one that did not win last time.
    // Ready is gated by reset_n so that no handshake can complete in a reset
    // cycle.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        accept_en  = reset_n && (state_q == ST_IDLE);
        req0_ready = accept_en && req0_valid && !grant;
        req1_ready = accept_en && req1_valid && grant;
        handshake  = req0_ready || req1_ready;
        sel_a      = grant ? req1_a  : req0_a;
        sel_b      = grant ? req1_b  : req0_b;
        sel_op     = grant ? req1_op : req0_op;
    end

    always_comb begin
        // NOTE: every variable written here is defaulted to its held value
        // first, so no path through the case leaves one unassigned (no latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_y_d      = rsp_y_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    alu_op_d     = sel_op;
                    last_grant_d = grant;
                    rsp_id_d     = grant;
                    if ({1'b0, sel_op} < NUM_OPS_W) begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_W'(SETTLE - 1);
                    end else begin
                        // Illegal opcode: the ALU result is never looked at,
                        // so respond right away with an error.
                        rsp_err_d   = 1'b1;
                        rsp_y_d     = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_y_d     = alu_y;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_grant resets to 1 so that requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // flop samples the values from before this edge.
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_y_q      <= rsp_y_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter_ctrl
//
// Directed bench for alu_arbiter_ctrl with the default parameters
// (WIDTH=4, OPW=3, NUM_OPS=6, SETTLE=1).
//
// The ALU is stubbed as y = ~(a ^ b). Inputs change 1 ns after each rising
// edge, and outputs are compared on the falling edge.
//
// Each table row describes one clock cycle:
//   - the inputs driven in that cycle,
//   - the hand-computed outputs expected in that cycle.
// Reset in SETTLE and reset in RESP are exercised by hand-written sequences
// after the table.
// -----------------------------------------------------------------------------
module tb_alu_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic [2:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic [2:0] req1_op;
    logic [3:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_op;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [3:0] rsp_y;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // ALU stub
    assign alu_y = ~(alu_a ^ alu_b);

    alu_arbiter_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_y      (alu_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    typedef struct {
        logic       v0;
        logic [3:0] a0, b0;
        logic [2:0] op0;
        logic       v1;
        logic [3:0] a1, b1;
        logic [2:0] op1;
        logic       rr;
        // expected outputs
        logic       rdy0, rdy1, bsy, rv, id, err;
        logic [3:0] y, a, b;
        logic [2:0] op;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic [2:0] op0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                       input logic [2:0] op1, input logic rr,
                       input logic rdy0, input logic rdy1, input logic bsy,
                       input logic rv, input logic id, input logic err,
                       input logic [3:0] y, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op);
        vec_t v;
        v.v0 = v0;  v.a0 = a0;  v.b0 = b0;  v.op0 = op0;
        v.v1 = v1;  v.a1 = a1;  v.b1 = b1;  v.op1 = op1;
        v.rr = rr;
        v.rdy0 = rdy0;  v.rdy1 = rdy1;  v.bsy = bsy;  v.rv = rv;
        v.id = id;  v.err = err;  v.y = y;  v.a = a;  v.b = b;  v.op = op;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Output bundle: {rdy0, rdy1, busy, rsp_valid, rsp_id, rsp_err, rsp_y,
    //                 alu_a, alu_b, alu_op}
    function automatic logic [31:0] dut_bundle();
        return {11'd0, req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_err,
                rsp_y, alu_a, alu_b, alu_op};
    endfunction

    function automatic logic [31:0] exp_bundle(input vec_t v);
        return {11'd0, v.rdy0, v.rdy1, v.bsy, v.rv, v.id, v.err, v.y, v.a, v.b, v.op};
    endfunction

    task automatic drive_reqs(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                              input logic [2:0] op0,
                              input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                              input logic [2:0] op1);
        req0_valid = v0;  req0_a = a0;  req0_b = b0;  req0_op = op0;
        req1_valid = v1;  req1_a = a1;  req1_b = b1;  req1_op = op1;
    endtask

    initial begin
        bit got_rsp;

        // Cycle-by-cycle script starting at the first cycle after reset.
        //    v0 a0    b0    op0   v1 a1    b1    op1   rr | rdy0 rdy1 bsy rv id err y     a     b     op
        // Single legal op from req0 (y = ~(A^6) = 3), with req1 contending.
        // req1 then issues illegal op 7.
        add(1, 4'hA, 4'h6, 3'd2, 1, 4'h1, 4'h2, 3'd7, 1,  1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0);
        add(0, 4'hA, 4'h6, 3'd2, 1, 4'h1, 4'h2, 3'd7, 1,  0, 0, 1, 0, 0, 0, 4'h0, 4'hA, 4'h6, 3'd2);
        add(0, 4'hA, 4'h6, 3'd2, 1, 4'h1, 4'h2, 3'd7, 1,  0, 0, 1, 1, 0, 0, 4'h3, 4'hA, 4'h6, 3'd2);
        add(0, 4'hA, 4'h6, 3'd2, 1, 4'h1, 4'h2, 3'd7, 1,  0, 1, 0, 0, 0, 0, 4'h3, 4'hA, 4'h6, 3'd2);
        add(0, 4'h0, 4'h0, 3'd0, 0, 4'h0, 4'h0, 3'd0, 1,  0, 0, 1, 1, 1, 1, 4'h0, 4'h1, 4'h2, 3'd7);
        // Contention, four ops: req0 3/5/1 -> 9, req1 9/4/0 -> 2.
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  1, 0, 0, 0, 1, 1, 4'h0, 4'h1, 4'h2, 3'd7);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  0, 0, 1, 0, 0, 1, 4'h0, 4'h3, 4'h5, 3'd1);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  0, 0, 1, 1, 0, 0, 4'h9, 4'h3, 4'h5, 3'd1);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  0, 1, 0, 0, 0, 0, 4'h9, 4'h3, 4'h5, 3'd1);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  0, 0, 1, 0, 1, 0, 4'h9, 4'h9, 4'h4, 3'd0);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  0, 0, 1, 1, 1, 0, 4'h2, 4'h9, 4'h4, 3'd0);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  1, 0, 0, 0, 1, 0, 4'h2, 4'h9, 4'h4, 3'd0);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  0, 0, 1, 0, 0, 0, 4'h2, 4'h3, 4'h5, 3'd1);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  0, 0, 1, 1, 0, 0, 4'h9, 4'h3, 4'h5, 3'd1);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  0, 1, 0, 0, 0, 0, 4'h9, 4'h3, 4'h5, 3'd1);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  0, 0, 1, 0, 1, 0, 4'h9, 4'h9, 4'h4, 3'd0);
        // Back-pressure: rsp_ready low for 5 cycles. Everything holds while
        // both requesters stay valid.
        for (int i = 0; i < 5; i++)
            add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 0,  0, 0, 1, 1, 1, 0, 4'h2, 4'h9, 4'h4, 3'd0);
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  0, 0, 1, 1, 1, 0, 4'h2, 4'h9, 4'h4, 3'd0);
        // Response handshake done: req0 is accepted in the very next cycle.
        add(1, 4'h3, 4'h5, 3'd1, 1, 4'h9, 4'h4, 3'd0, 1,  1, 0, 0, 0, 1, 0, 4'h2, 4'h9, 4'h4, 3'd0);
        add(0, 4'h0, 4'h0, 3'd0, 0, 4'h0, 4'h0, 3'd0, 0,  0, 0, 1, 0, 0, 0, 4'h2, 4'h3, 4'h5, 3'd1);
        add(0, 4'h0, 4'h0, 3'd0, 0, 4'h0, 4'h0, 3'd0, 1,  0, 0, 1, 1, 0, 0, 4'h9, 4'h3, 4'h5, 3'd1);
        add(0, 4'h0, 4'h0, 3'd0, 0, 4'h0, 4'h0, 3'd0, 1,  0, 0, 0, 0, 0, 0, 4'h9, 4'h3, 4'h5, 3'd1);

        // Reset held for 3 cycles with both requesters valid.
        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        drive_reqs(1, 4'hA, 4'h6, 3'd2, 1, 4'h1, 4'h2, 3'd7);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("reset_c%0d", i), dut_bundle(), 32'd0);
        end

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset_n   = 1'b1;
            rsp_ready = vecs[i].rr;
            drive_reqs(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].op0,
                       vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].op1);
            @(negedge clk);
            check($sformatf("vec%0d", i), dut_bundle(), exp_bundle(vecs[i]));
        end

        // Reset during SETTLE. last_grant is 0 here, so req1 goes alone.
        @(posedge clk); #1;
        drive_reqs(0, 4'h0, 4'h0, 3'd0, 1, 4'h5, 4'h5, 3'd3);
        @(negedge clk);
        check("settle_accept_rdy", {30'd0, req0_ready, req1_ready}, 32'b01);
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive_reqs(1, 4'h2, 4'h2, 3'd4, 1, 4'h5, 4'h5, 3'd3);
        @(negedge clk);
        check("settle_in_reset", {27'd0, req0_ready, req1_ready, busy, alu_a},
              {27'd0, 1'b0, 1'b0, 1'b1, 4'h5});
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("settle_after_reset", {22'd0, req0_ready, req1_ready, busy, rsp_valid,
                                     rsp_id, alu_a, rsp_y},
              {22'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});

        // req0 (2/2/4 -> F) was accepted above; hold its response.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_reqs(0, 4'h0, 4'h0, 3'd0, 0, 4'h0, 4'h0, 3'd0);
        @(negedge clk);
        check("no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
        got_rsp = 1'b0;
        for (int i = 0; i < 8 && !got_rsp; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            got_rsp = rsp_valid;
        end
        check("rsp_timeout", {31'd0, got_rsp}, 32'd1);
        check("rsp_after_reset", {26'd0, rsp_id, rsp_err, rsp_y}, {26'd0, 1'b0, 1'b0, 4'hF});

        // Reset during RESP with rsp_ready low: the response is dropped.
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive_reqs(1, 4'h7, 4'h1, 3'd5, 1, 4'h5, 4'h5, 3'd3);
        @(negedge clk);
        check("resp_in_reset", {29'd0, req0_ready, req1_ready, rsp_valid}, 32'b001);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("resp_after_reset", {21'd0, req0_ready, req1_ready, busy, rsp_valid,
                                   rsp_err, rsp_y, alu_a},
              {21'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
        @(posedge clk); #1;
        drive_reqs(0, 4'h0, 4'h0, 3'd0, 0, 4'h0, 4'h0, 3'd0);
        @(negedge clk);
        check("req0_wins_after_reset", {19'd0, busy, rsp_id, rsp_valid, alu_a, alu_b, alu_op},
              {19'd0, 1'b1, 1'b0, 1'b0, 4'h7, 4'h1, 3'd5});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
